// File: rtl/spi_ram_if.sv
// Byte-wide link between an SPI slave front end and the spi_ram command decoder.
// The master side is the SPI slave; the slave side is the RAM.
interface spi_ram_if;
  logic [9:0] din;
  logic       rx_valid;
  logic [7:0] dout;
  logic       tx_valid;
  logic       err;

  modport master (output din, rx_valid, input dout, tx_valid, err);
  modport slave  (input din, rx_valid, output dout, tx_valid, err);
endinterface

// File: rtl/spi_ram.sv
// Command-driven single-port RAM behind an SPI slave: address/data writes, address/data reads,
// with each read presented on dout under tx_valid for TX_CYCLES clocks.
module spi_ram #(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8,
  parameter int TX_CYCLES = 8
) (
  input logic     clk,
  input logic     rst_n,
  spi_ram_if.slave bus
);

  localparam int DATA_W = 8;
  localparam int CNT_W  = (TX_CYCLES > 1) ? $clog2(TX_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TX_CYCLES - 1);

  typedef enum logic {IDLE, SEND} tx_state_t;

  logic [DATA_W-1:0]    mem [MEM_DEPTH];
  logic                 rx_valid_d;
  logic [ADDR_SIZE-1:0] wr_addr, rd_addr;
  logic                 wr_addr_vld, rd_addr_vld;
  tx_state_t            state, state_next;
  logic [CNT_W-1:0]     cnt, cnt_next;
  logic                 tx_next, err_next;
  logic                 accept, wr_ok, rd_ok;
  logic [1:0]           cmd;

  // A held-high rx_valid only counts once: commands fire on its rising edge.
  assign accept = bus.rx_valid & ~rx_valid_d;
  assign cmd    = bus.din[9:8];
  assign wr_ok  = accept && (cmd == 2'b01) && wr_addr_vld;
  assign rd_ok  = accept && (cmd == 2'b11) && rd_addr_vld && (state == IDLE);

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    tx_next    = bus.tx_valid;
    err_next   = 1'b0;
    case (state)
      IDLE: begin
        if (rd_ok) begin
          state_next = SEND;
          cnt_next   = CNT_LOAD;
          tx_next    = 1'b1;
        end
      end
      SEND: begin
        if (cnt == '0) begin
          state_next = IDLE;
          tx_next    = 1'b0;
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
    // Rejected: data write without address, or read without address / while still sending.
    if (accept) begin
      if (cmd == 2'b01 && !wr_addr_vld)
        err_next = 1'b1;
      if (cmd == 2'b11 && (!rd_addr_vld || state == SEND))
        err_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_valid_d   <= 1'b0;
      state        <= IDLE;
      cnt          <= '0;
      bus.tx_valid <= 1'b0;
      bus.err      <= 1'b0;
      bus.dout     <= '0;
      wr_addr      <= '0;
      rd_addr      <= '0;
      wr_addr_vld  <= 1'b0;
      rd_addr_vld  <= 1'b0;
    end else begin
      rx_valid_d   <= bus.rx_valid;
      state        <= state_next;
      cnt          <= cnt_next;
      bus.tx_valid <= tx_next;
      bus.err      <= err_next;
      if (accept && cmd == 2'b00) begin
        wr_addr     <= bus.din[ADDR_SIZE-1:0];
        wr_addr_vld <= 1'b1;
      end
      if (accept && cmd == 2'b10) begin
        rd_addr     <= bus.din[ADDR_SIZE-1:0];
        rd_addr_vld <= 1'b1;
      end
      if (rd_ok)
        bus.dout <= mem[rd_addr];
    end
  end

  // Array contents survive reset, so the write port has no reset term.
  always_ff @(posedge clk) begin
    if (wr_ok)
      mem[wr_addr] <= bus.din[DATA_W-1:0];
  end

endmodule

// File: tb/tb_spi_ram.sv
// Directed and randomized bench for spi_ram with a cycle-level behavioural reference model.
module tb_spi_ram;
  localparam int TXC = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  spi_ram_if bus();

  spi_ram #(.MEM_DEPTH(256), .ADDR_SIZE(8), .TX_CYCLES(TXC)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  logic [7:0] ref_mem [256];
  logic [7:0] m_wa, m_ra, m_dout;
  bit         m_wv, m_rv, m_prev, m_err;
  int         m_left;
  int         tx_seen, err_seen;
  logic [7:0] pre [16];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_wa = 0; m_ra = 0; m_wv = 0; m_rv = 0;
    m_prev = 0; m_err = 0; m_left = 0; m_dout = 0;
  endtask

  task automatic model_edge();
    bit busy, acc;
    logic [1:0] c;
    logic [7:0] pl;
    if (!rst_n) begin
      model_reset();
      return;
    end
    busy = (m_left > 0);
    if (m_left > 0) m_left--;
    m_err = 0;
    acc = bus.rx_valid && !m_prev;
    m_prev = bus.rx_valid;
    c  = bus.din[9:8];
    pl = bus.din[7:0];
    if (acc) begin
      case (c)
        2'b00: begin m_wa = pl; m_wv = 1; end
        2'b01: if (m_wv) ref_mem[m_wa] = pl; else m_err = 1;
        2'b10: begin m_ra = pl; m_rv = 1; end
        default: if (m_rv && !busy) begin m_dout = ref_mem[m_ra]; m_left = TXC; end
                 else m_err = 1;
      endcase
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("tx_valid", 32'(bus.tx_valid), 32'(m_left > 0));
    check("dout", 32'(bus.dout), 32'(m_dout));
    check("err", 32'(bus.err), 32'(m_err));
    if (bus.tx_valid) tx_seen++;
    if (bus.err) err_seen++;
  endtask

  task automatic send(input logic [9:0] d, input int hold = 1);
    bus.din = d;
    bus.rx_valid = 1'b1;
    repeat (hold) tick();
    bus.rx_valid = 1'b0;
    tick();
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
    check("rst_dout", 32'(bus.dout), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    model_reset();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [1:0] c;
    logic [7:0] pl;
    bus.din = '0;
    bus.rx_valid = 1'b0;
    model_reset();
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_dout", 32'(bus.dout), 32'd0);
    check("reset_tx_valid", 32'(bus.tx_valid), 32'd0);
    check("reset_err", 32'(bus.err), 32'd0);
    rst_n = 1'b1;

    // preload low addresses so random reads hit known data
    for (int a = 0; a < 16; a++) begin
      pre[a] = 8'($urandom);
      send({2'b00, 8'(a)});
      send({2'b01, pre[a]});
    end

    // basic write then read
    tx_seen = 0; err_seen = 0;
    send(10'h0A5); send(10'h13C); send(10'h2A5); send(10'h300);
    idle(10);
    check("wr_rd_tx_cycles", 32'(tx_seen), 32'd8);
    check("wr_rd_dout", 32'(bus.dout), 32'h3C);
    check("wr_rd_no_err", 32'(err_seen), 32'd0);

    // held rx_valid writes once
    send(10'h040); send(10'h177, 12); send(10'h240);
    tx_seen = 0;
    send(10'h300);
    idle(10);
    check("held_dout", 32'(bus.dout), 32'h77);
    check("held_tx_cycles", 32'(tx_seen), 32'd8);

    // illegal order after reset
    async_reset();
    tx_seen = 0; err_seen = 0;
    send(10'h155);
    check("nowa_err", 32'(err_seen), 32'd1);
    send(10'h300);
    idle(3);
    check("nora_err", 32'(err_seen), 32'd2);
    check("nora_no_tx", 32'(tx_seen), 32'd0);
    send(10'h200); send(10'h300);
    idle(9);
    check("mem_unchanged", 32'(bus.dout), 32'(pre[0]));

    // busy read rejected
    send(10'h2A5);
    tx_seen = 0; err_seen = 0;
    bus.din = 10'h300; bus.rx_valid = 1'b1;
    tick();
    bus.rx_valid = 1'b0;
    tick(); tick();
    send(10'h3FF);
    idle(10);
    check("busy_tx_cycles", 32'(tx_seen), 32'd8);
    check("busy_err", 32'(err_seen), 32'd1);
    check("busy_dout", 32'(bus.dout), 32'h3C);

    // write to the address being read
    send(10'h0A5);
    tx_seen = 0;
    send(10'h300);
    send(10'h1FF);
    check("wr_during_send_dout", 32'(bus.dout), 32'h3C);
    idle(8);
    check("wr_during_send_tx", 32'(tx_seen), 32'd8);
    send(10'h300);
    idle(9);
    check("reread_dout", 32'(bus.dout), 32'hFF);

    // reset mid-send
    send(10'h300);
    tick(); tick();
    async_reset();
    err_seen = 0;
    send(10'h300);
    check("post_rst_err", 32'(err_seen), 32'd1);
    send(10'h2A5); send(10'h300);
    idle(9);
    check("post_rst_mem", 32'(bus.dout), 32'hFF);

    // randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      c = 2'($urandom_range(0, 3));
      if (c == 2'b00 || c == 2'b10) pl = 8'($urandom_range(0, 15));
      else pl = 8'($urandom);
      bus.din = {c, pl};
      bus.rx_valid = ($urandom_range(0, 2) != 0);
      tick();
    end
    bus.rx_valid = 1'b0;
    idle(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
